mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Iterative multi-cycle multiply/divide responder owning the HI/LO pair. The datapath issues
//   MULT/DIV/MADD/MSUB/MTHI/MTLO requests and stalls on oBusy. It collects the {HI,LO} result
//   on oDone, then reads HI/LO through oHI/oLO for MFHI/MFLO.
//   Replaces single-cycle '*' '/' '%' logic with a radix-2 shift-add / restoring-divide engine.
// PARAMETERS
//   WIDTH  32  operand width; HI and LO are WIDTH bits each; iteration count = WIDTH
// PORTS
//   iCLK      in   1      clock, all state updates on posedge
//   iRST      in   1      synchronous, active-high reset
//   iStart    in   1      request strobe; sampled only in IDLE
//   iOp       in   5      operation code (shared ALU op constants: OPMULT..OPMSUBU, OPMTHI, OPMTLO)
//   iA        in   WIDTH  operand A / dividend / MTHI-MTLO source
//   iB        in   WIDTH  operand B / divisor
//   iFlush    in   1      abort in-flight op; HI/LO keep pre-op values
//   oBusy     out  1      high while an iterative op is in flight
//   oDone     out  1      one-cycle pulse; oHI/oLO hold the new result in that cycle
//   oDivZero  out  1      valid with oDone; 1 if DIV/DIVU had iB==0
//   oHI       out  WIDTH  HI register
//   oLO       out  WIDTH  LO register
// BEHAVIOUR
//   Reset (iRST=1 at posedge): state=IDLE; HI=LO=0; oBusy=oDone=oDivZero=0. Aborts any op.
//   Priority per edge: iRST > iFlush > iStart.
//   States: IDLE -> MUL|DIV (WIDTH cycles) -> FIX (1) -> DONE (1) -> IDLE.
//   Accept: iStart=1 in IDLE with iterative op. Capture |iA|,|iB| (signed ops) or raw (unsigned).
//     Capture result signs; clear counter. Next state MUL or DIV.
//   Latency: accept edge = cycle 0; oBusy=1 cycles 1..WIDTH+1; oDone=1 in cycle WIDTH+2.
//   oBusy=0 in DONE and IDLE.
//   iStart outside IDLE is ignored (no queueing); the requester must wait for oDone.
//   MTHI/MTLO: accepted in IDLE only. HI<=iA or LO<=iA at the accepting edge.
//     No busy and no oDone pulse.
//   Unknown iOp with iStart is ignored; the unit stays IDLE.
//   MUL: 2*WIDTH-bit product, one shift-add per cycle, LSB-first.
//   FIX after MUL: negate product if signs differ (signed ops only).
//     MULT/MULTU: {HI,LO}<=p. MADD/MADDU: {HI,LO}<={HI,LO}+p. MSUB/MSUBU: {HI,LO}<={HI,LO}-p.
//     All sums are mod 2^(2*WIDTH).
//   DIV: restoring division, one quotient bit per cycle, MSB-first.
//   FIX after DIV (signed): quotient negated if signs differ; remainder takes the dividend sign.
//     Writes LO<=quotient, HI<=remainder.
//   Divide by zero: full latency still applies. LO<=all ones, HI<=iA (original dividend).
//     oDivZero=1 with oDone.
//   Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (no trap).
//   HI/LO are written only at the FIX->DONE edge (or by MTHI/MTLO).
//     oHI/oLO show old values while busy.
//   iFlush while busy: next state IDLE, no oDone, HI/LO unchanged. iFlush in IDLE: no effect.
//   oDivZero is 0 in every cycle except a DONE cycle of a zero-divisor divide.
// STRUCTURE
//   Op codes (5-bit) and state enum live in the shared ALU op package; no local copies.
//   One control FSM plus shared datapath: 2*WIDTH accumulator/remainder register,
//     WIDTH-bit operand register, counter of $clog2(WIDTH)+1 bits.
//   Optional sub-module: mdu_sign_fix (combinational negate/accumulate used in FIX).
// TESTING
//   1 MULT iA=7 iB=-3 -> oDone at cycle 34, {HI,LO}=0xFFFFFFFF_FFFFFFEB; oBusy=1 cycles 1..33.
//   2 DIVU 100/7 -> LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   3 DIV 5/0 -> LO=0xFFFFFFFF, HI=5, oDivZero=1 for exactly the oDone cycle.
//     DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//   4 MTLO 10, MTHI 0, then MADD 3*4 -> LO=22, HI=0.
//     Then MSUBU 1*23 -> {HI,LO}=0xFFFFFFFF_FFFFFFFF.
//   5 iStart (MULT 2*2) at cycle 5 of a busy DIVU -> ignored; only the DIVU result and one oDone.
//   6 iRST at cycle 10 of MULTU -> next cycle oBusy=0, HI=LO=0, no oDone.
//     iFlush at cycle 10 -> HI/LO keep prior values.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared ALU op package: multiply/divide op codes, MDU state encoding and op-decode helpers.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package mult_div_unit_pkg;

  localparam int MDU_WIDTH = 32;

  // 5-bit ALU op codes owned by the multiply/divide unit
  localparam logic [4:0] OPMULT  = 5'h10;
  localparam logic [4:0] OPMULTU = 5'h11;
  localparam logic [4:0] OPDIV   = 5'h12;
  localparam logic [4:0] OPDIVU  = 5'h13;
  localparam logic [4:0] OPMADD  = 5'h14;
  localparam logic [4:0] OPMADDU = 5'h15;
  localparam logic [4:0] OPMSUB  = 5'h16;
  localparam logic [4:0] OPMSUBU = 5'h17;
  localparam logic [4:0] OPMTHI  = 5'h18;
  localparam logic [4:0] OPMTLO  = 5'h19;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_t;

  // Ops that run through the multi-cycle engine
  function automatic logic op_is_iter(input logic [4:0] op);
    return (op >= OPMULT) && (op <= OPMSUBU);
  endfunction

  function automatic logic op_is_div(input logic [4:0] op);
    return (op == OPDIV) || (op == OPDIVU);
  endfunction

  function automatic logic op_is_signed(input logic [4:0] op);
    return (op == OPMULT) || (op == OPDIV) || (op == OPMADD) || (op == OPMSUB);
  endfunction

  function automatic logic op_is_madd(input logic [4:0] op);
    return (op == OPMADD) || (op == OPMADDU);
  endfunction

  function automatic logic op_is_msub(input logic [4:0] op);
    return (op == OPMSUB) || (op == OPMSUBU);
  endfunction

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// Result fix-up: sign correction of the raw engine result plus accumulate/subtract into {HI,LO}.
// Latency: purely combinational, consumed in the FIX cycle.
// Backpressure: none; outputs follow inputs.
// Ports: i_acc raw product or {remainder,quotient}; i_hi/i_lo current HI/LO; i_is_div, i_madd,
//        i_msub select the result form; i_neg_res / i_neg_rem sign corrections; i_dz zero divisor;
//        o_hi/o_lo the value to be written into HI/LO.
module mult_div_unit_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_hi,
  input  logic [WIDTH-1:0]   i_lo,
  input  logic               i_is_div,
  input  logic               i_madd,
  input  logic               i_msub,
  input  logic               i_neg_res,
  input  logic               i_neg_rem,
  input  logic               i_dz,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);

  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_hilo;
  logic [2*WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  always_comb begin
    w_prod = i_neg_res ? (~i_acc + 1'b1) : i_acc;
    w_hilo = {i_hi, i_lo};
    if (i_madd)      w_mul_res = w_hilo + w_prod;
    else if (i_msub) w_mul_res = w_hilo - w_prod;
    else             w_mul_res = w_prod;

    w_quo = i_neg_res ? (~i_acc[WIDTH-1:0] + 1'b1) : i_acc[WIDTH-1:0];
    // With a zero divisor every trial subtract succeeds, so the remainder field ends up holding
    // |dividend|; re-applying the dividend sign recovers the original dividend for HI.
    w_rem = i_neg_rem ? (~i_acc[2*WIDTH-1:WIDTH] + 1'b1) : i_acc[2*WIDTH-1:WIDTH];

    if (i_is_div) begin
      o_hi = w_rem;
      o_lo = i_dz ? '1 : w_quo;
    end else begin
      o_hi = w_mul_res[2*WIDTH-1:WIDTH];
      o_lo = w_mul_res[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit owning HI/LO (shift-add multiply, restoring divide).
// Latency: accept edge = cycle 0, oBusy cycles 1..WIDTH+1, oDone pulse in cycle WIDTH+2.
// Backpressure: none queued; iStart is only sampled in IDLE, requester stalls on oBusy.
// Ports: iCLK/iRST clock and sync active-high reset; iStart/iOp/iA/iB request; iFlush abort;
//        oBusy in-flight flag; oDone result pulse; oDivZero zero-divisor flag; oHI/oLO registers.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [4:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iFlush,
  output logic             oBusy,
  output logic             oDone,
  output logic             oDivZero,
  output logic [WIDTH-1:0] oHI,
  output logic [WIDTH-1:0] oLO
);

  localparam int CW = $clog2(WIDTH) + 1;

  mdu_state_t         r_state;
  mdu_state_t         w_next;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic [CW-1:0]      r_cnt;
  logic [4:0]         r_op;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_last;
  logic               w_in_flight;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_div_step;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign w_accept    = iStart && op_is_iter(iOp);
  assign w_last      = (r_cnt == CW'(WIDTH - 1));
  assign w_in_flight = (r_state == ST_MUL) || (r_state == ST_DIV) || (r_state == ST_FIX);

  // Operand capture: magnitudes for signed ops, raw bits otherwise
  assign w_a_neg = op_is_signed(iOp) && iA[WIDTH-1];
  assign w_b_neg = op_is_signed(iOp) && iB[WIDTH-1];
  assign w_a_abs = w_a_neg ? (~iA + 1'b1) : iA;
  assign w_b_abs = w_b_neg ? (~iB + 1'b1) : iB;

  // Multiply step: r_acc = {partial product, remaining multiplier bits}; add multiplicand into
  // the upper half when the current LSB is set, then shift the whole pair right by one.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide step: r_acc = {partial remainder, remaining dividend bits}; shift left, trial subtract
  // the divisor from the (WIDTH+1)-bit shifted remainder, shift the quotient bit in at the LSB.
  assign w_div_ge   = (r_acc[2*WIDTH-1:WIDTH-1] >= {1'b0, r_opb});
  assign w_div_diff = r_acc[2*WIDTH-2:WIDTH-1] - r_opb;
  assign w_div_step = {(w_div_ge ? w_div_diff : r_acc[2*WIDTH-2:WIDTH-1]),
                       r_acc[WIDTH-2:0], w_div_ge};

  mult_div_unit_sign_fix #(
    .WIDTH(WIDTH)
  ) u_sign_fix (
    .i_acc    (r_acc),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_is_div (op_is_div(r_op)),
    .i_madd   (op_is_madd(r_op)),
    .i_msub   (op_is_msub(r_op)),
    .i_neg_res(r_neg_res),
    .i_neg_rem(r_neg_rem),
    .i_dz     (r_dz),
    .o_hi     (w_fix_hi),
    .o_lo     (w_fix_lo)
  );

  // Control FSM: state register
  always_ff @(posedge iCLK) begin
    if (iRST) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Control FSM: next state and outputs
  always_comb begin
    w_next   = r_state;
    oBusy    = 1'b0;
    oDone    = 1'b0;
    oDivZero = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = op_is_div(iOp) ? ST_DIV : ST_MUL;
      end
      ST_MUL, ST_DIV: begin
        oBusy = 1'b1;
        if (w_last) w_next = ST_FIX;
      end
      ST_FIX: begin
        oBusy  = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: begin
        oDone    = 1'b1;
        oDivZero = r_dz;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (iFlush && w_in_flight) w_next = ST_IDLE;
  end

  // Engine datapath
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_acc     <= '0;
      r_opb     <= '0;
      r_cnt     <= '0;
      r_op      <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_acc     <= {{WIDTH{1'b0}}, w_a_abs};
            r_opb     <= w_b_abs;
            r_cnt     <= '0;
            r_op      <= iOp;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_dz      <= op_is_div(iOp) && (iB == '0);
          end
        end
        ST_MUL: begin
          r_acc <= w_mul_step;
          r_cnt <= r_cnt + CW'(1);
        end
        ST_DIV: begin
          r_acc <= w_div_step;
          r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // HI/LO: written by the FIX->DONE edge (unless flushed) or directly by MTHI/MTLO in IDLE
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == ST_FIX) begin
      if (!iFlush) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end
    end else if ((r_state == ST_IDLE) && iStart) begin
      if (iOp == OPMTHI) r_hi <= iA;
      if (iOp == OPMTLO) r_lo <= iA;
    end
  end

  assign oHI = r_hi;
  assign oLO = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W = 32;

  logic         iCLK = 1'b0;
  logic         iRST;
  logic         iStart;
  logic [4:0]   iOp;
  logic [W-1:0] iA;
  logic [W-1:0] iB;
  logic         iFlush;
  logic         oBusy;
  logic         oDone;
  logic         oDivZero;
  logic [W-1:0] oHI;
  logic [W-1:0] oLO;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] res_hilo;
  logic        post_busy;
  logic [63:0] post_hilo;

  mult_div_unit #(.WIDTH(W)) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iStart  (iStart),
    .iOp     (iOp),
    .iA      (iA),
    .iB      (iB),
    .iFlush  (iFlush),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oDivZero(oDivZero),
    .oHI     (oHI),
    .oLO     (oLO)
  );

  always #5 iCLK = ~iCLK;

  // Advance one cycle; outputs are then sampled 1 time unit after the edge
  task automatic step;
    @(posedge iCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-cycle request (MTHI/MTLO/unknown op)
  task automatic issue1(input logic [4:0] op, input logic [W-1:0] a);
    iOp = op; iA = a; iB = '0; iStart = 1'b1;
    step;
    iStart = 1'b0;
  endtask

  // Issue an op and watch 60 cycles. act: 0 none, 1 start MULT 2*2 at cycle inj,
  // 2 assert iRST at cycle inj, 3 assert iFlush at cycle inj.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int inj, input int act, input logic exp_dz);
    int          done_cyc = 0;
    int          n_done = 0;
    int          bad_busy = 0;
    int          bad_dz = 0;
    int          bad_hold = 0;
    int          last_busy;
    logic [63:0] pre;
    pre       = {oHI, oLO};
    last_busy = (act >= 2) ? inj : W + 1;
    iOp = op; iA = a; iB = b; iStart = 1'b1;
    step;
    iStart = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (oDone === 1'b1) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc = c;
          res_hilo = {oHI, oLO};
        end
      end
      if (oBusy !== (c <= last_busy)) bad_busy++;
      if (oDivZero !== (exp_dz && (c == W + 2))) bad_dz++;
      if ((c <= last_busy) && ({oHI, oLO} !== pre)) bad_hold++;
      if ((act >= 2) && (c == inj + 1)) begin
        post_busy = oBusy;
        post_hilo = {oHI, oLO};
      end
      if (c == inj) begin
        case (act)
          1: begin iStart = 1'b1; iOp = OPMULT; iA = 32'd2; iB = 32'd2; end
          2: iRST = 1'b1;
          3: iFlush = 1'b1;
          default: ;
        endcase
      end
      step;
      iStart = 1'b0; iRST = 1'b0; iFlush = 1'b0;
    end
    check({tag, "/busy_pattern"}, 64'(bad_busy), 64'd0);
    check({tag, "/divzero_pattern"}, 64'(bad_dz), 64'd0);
    check({tag, "/hilo_hold"}, 64'(bad_hold), 64'd0);
    check({tag, "/done_cycle"}, 64'(done_cyc), (act >= 2) ? 64'd0 : 64'(W + 2));
    check({tag, "/done_count"}, 64'(n_done), (act >= 2) ? 64'd0 : 64'd1);
  endtask

  initial begin
    iRST = 1'b1; iStart = 1'b0; iOp = '0; iA = '0; iB = '0; iFlush = 1'b0;
    res_hilo = '0; post_busy = 1'b0; post_hilo = '0;
    step;
    step;
    iRST = 1'b0;

    // Reset state
    check("reset/busy", 64'(oBusy), 64'd0);
    check("reset/done", 64'(oDone), 64'd0);
    check("reset/divzero", 64'(oDivZero), 64'd0);
    check("reset/hilo", {oHI, oLO}, 64'd0);

    // Unknown op is ignored
    issue1(5'h01, 32'hDEAD_BEEF);
    check("unknown/busy", 64'(oBusy), 64'd0);
    check("unknown/hilo", {oHI, oLO}, 64'd0);

    // Multiply
    run_op("mult_7x-3", OPMULT, 32'd7, 32'hFFFF_FFFD, 0, 0, 1'b0);
    check("mult_7x-3/result", res_hilo, 64'hFFFF_FFFF_FFFF_FFEB);

    // Divide
    run_op("divu_100/7", OPDIVU, 32'd100, 32'd7, 0, 0, 1'b0);
    check("divu_100/7/result", res_hilo, {32'd2, 32'd14});
    run_op("div_-7/2", OPDIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
    check("div_-7/2/result", res_hilo, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_5/0", OPDIV, 32'd5, 32'd0, 0, 0, 1'b1);
    check("div_5/0/result", res_hilo, {32'd5, 32'hFFFF_FFFF});
    check("div_5/0/divzero_after", 64'(oDivZero), 64'd0);
    run_op("div_ovf", OPDIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
    check("div_ovf/result", res_hilo, {32'd0, 32'h8000_0000});

    // MTLO/MTHI then accumulate
    issue1(OPMTLO, 32'd10);
    check("mtlo/busy", 64'(oBusy), 64'd0);
    check("mtlo/done", 64'(oDone), 64'd0);
    check("mtlo/lo", 64'(oLO), 64'd10);
    issue1(OPMTHI, 32'd0);
    check("mthi/hilo", {oHI, oLO}, {32'd0, 32'd10});
    run_op("madd_3x4", OPMADD, 32'd3, 32'd4, 0, 0, 1'b0);
    check("madd_3x4/result", res_hilo, {32'd0, 32'd22});
    run_op("msubu_1x23", OPMSUBU, 32'd1, 32'd23, 0, 0, 1'b0);
    check("msubu_1x23/result", res_hilo, 64'hFFFF_FFFF_FFFF_FFFF);

    // Start while busy is ignored
    run_op("divu_busy_start", OPDIVU, 32'd50, 32'd6, 5, 1, 1'b0);
    check("divu_busy_start/result", res_hilo, {32'd2, 32'd8});

    // Reset mid-op
    run_op("multu_rst", OPMULTU, 32'd3, 32'd5, 10, 2, 1'b0);
    check("multu_rst/busy_after", 64'(post_busy), 64'd0);
    check("multu_rst/hilo_after", post_hilo, 64'd0);

    // Flush mid-op keeps HI/LO
    issue1(OPMTHI, 32'h1234);
    issue1(OPMTLO, 32'h5678);
    run_op("multu_flush", OPMULTU, 32'd3, 32'd5, 10, 3, 1'b0);
    check("multu_flush/busy_after", 64'(post_busy), 64'd0);
    check("multu_flush/hilo_after", post_hilo, {32'h1234, 32'h5678});

    // Unit still functional after flush
    run_op("multu_3x5", OPMULTU, 32'd3, 32'd5, 0, 0, 1'b0);
    check("multu_3x5/result", res_hilo, {32'd0, 32'd15});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
